uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Single-clock, run-time-configurable UART transmitter. It succeeds the fixed 8N1 dual-clock transmitter. Bit timing comes from an internal baud divider on clk_i, so no separate baud clock is used. It pops bytes from the TX FIFO with a one-cycle read strobe and serialises frames with the following options: 5–8 data bits, optional even/odd parity, 1 or 2 stop bits, and line break. It sits between the APB-side TX FIFO and the tx pad.

Parameters:
DIV_W, 16, width of the baud divisor; bit period = baud_div_i+1 clk_i cycles.
DATA_W, 8, FIFO data width; maximum data bits per frame.

Ports:
clk_i  in  1  system clock; all logic rises on clk_i
rstn_i  in  1  reset, asynchronous, active-low
tx_en_i  in  1  transmit enable from CTRL register
baud_div_i  in  DIV_W  bit period minus one, in clk_i cycles
data_bits_i  in  2  frame data length: 0=5, 1=6, 2=7, 3=8 bits
parity_en_i  in  1  1 = append parity bit
parity_odd_i  in  1  1 = odd parity, 0 = even parity
stop2_i  in  1  1 = two stop bits, 0 = one stop bit
break_i  in  1  request: drive line low while idle
fifo_data_i  in  DATA_W  FIFO read data, valid the cycle after fifo_rd_o
fifo_empty_i  in  1  FIFO empty flag
fifo_rd_o  out  1  one-cycle FIFO pop strobe
tx_o  out  1  serial line, idle high
busy_o  out  1  a frame is in progress
done_o  out  1  one-cycle pulse at the end of a frame
tx_stat_o  out  2  {done_o, busy_o}, for the STATUS register

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame): state=IDLE, tx_o=1, fifo_rd_o=0, busy_o=0, done_o=0, all counters 0.
- All outputs are registered.
- States and transitions:
  - IDLE: if break_i=1, then tx_o=0 and no frame starts. Otherwise, if tx_en_i=1 and fifo_empty_i=0, go to FETCH with fifo_rd_o=1 for exactly that cycle.
  - FETCH: go to LOAD.
  - LOAD: capture fifo_data_i. Latch baud_div_i, data_bits_i, parity_en_i, parity_odd_i and stop2_i. Set busy_o=1. Go to START.
  - START: hold tx_o=0 for one bit period, then go to DATA.
  - DATA: shift out the latched byte LSB first. Send N = 5+data_bits_i bits. Bits at index N and above are ignored. Then go to PARITY if parity is enabled, else STOP.
  - PARITY: send XOR-reduce of the N data bits, inverted when parity_odd_i=1. Then go to STOP.
  - STOP: hold tx_o=1 for 1 or 2 bit periods. On the last cycle of the last stop bit, pulse done_o=1 and leave the state.
- After STOP:
  - If tx_en_i=1, fifo_empty_i=0 and break_i=0, go directly to FETCH. busy_o stays 1.
  - Otherwise go to IDLE with busy_o=0.
- Bit timing: every bit (start, data, parity, stop) lasts exactly baud_div_i+1 cycles, using the value latched in LOAD. baud_div_i=0 gives 1 cycle per bit. Config changes mid-frame have no effect until the next LOAD.
- Latency: IDLE detects the start condition in cycle T. fifo_rd_o is high in T+1, data is captured in T+2, and tx_o falls in T+3.
- Back-to-back frames: 2 extra high cycles (FETCH+LOAD) between the last stop bit and the next start bit. Exactly 2, never more.
- Frame length in cycles = (1+N+P+S)×(baud_div_i+1), where P = parity bit count and S = stop bit count.
- tx_en_i deasserted mid-frame: the current frame completes normally, then the block goes to IDLE. No pop occurs.
- fifo_empty_i is sampled only in IDLE and at the end of STOP. Exactly one pop per frame. A pop never occurs while busy mid-frame.
- break_i asserted mid-frame: ignored until the frame ends. The block then enters IDLE and drives tx_o=0 while break_i=1. The line returns high the cycle after break_i=0. Frames are blocked during break.
- tx_o is high in IDLE (no break), FETCH and LOAD.

Test Plan:
- 8N1, div=3, byte 0xA5:
  - fifo_rd_o pulses once, then tx_o falls 2 cycles later.
  - Bits are 0,1,0,1,0,0,1,0,1,1, each 4 cycles (40 cycles total).
  - done_o pulses on cycle 40; busy_o then falls.
- 7E1, div=1, byte 0xB5 (bit 7 ignored; data 0110101, four ones):
  - tx_o = start 0, then 1,0,1,0,1,1,0, then parity 0, then stop 1.
  - 10 bits × 2 cycles = 20 cycles.
- 5O2, div=0, byte 0xFF:
  - tx_o = 0,1,1,1,1,1, then parity 0, then 1,1 (9 cycles).
  - Repeat with parity_odd_i=0: parity bit = 1.
- Three bytes queued, 8N1, div=2:
  - Three pops, three done_o pulses.
  - Exactly 2 high cycles between each stop bit and the next start bit.
  - busy_o stays 1 until after the third frame.
- Reset in DATA bit 3 (rstn_i low 1 cycle), then release:
  - tx_o=1 and busy_o=0 immediately.
  - No pop until the start condition is re-seen.
  - Next byte is sent intact.
- break_i raised mid-frame with div=1:
  - The frame completes with a correct stop bit.
  - tx_o=0 while break_i=1, with no fifo_rd_o even though the FIFO is non-empty.
  - After break_i falls, tx_o=1 for one cycle, then the FETCH→LOAD sequence follows and a new frame starts.

Source files
------------

// File: rtl/uart_tx_cfg_if.sv
// FIFO read-side handshake between the TX FIFO and the UART transmitter.
// The transmitter is the master: it issues the pop strobe and consumes data.
interface uart_tx_cfg_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_empty;
    logic              fifo_rd;

    modport master (
        output fifo_rd,
        input  fifo_data,
        input  fifo_empty
    );

    modport slave (
        input  fifo_rd,
        output fifo_data,
        output fifo_empty
    );
endinterface

// File: rtl/uart_tx_cfg.sv
// Single-clock configurable UART transmitter: 5-8 data bits, optional
// even/odd parity, 1 or 2 stop bits, line break. Bit timing comes from an
// internal divider; frame configuration is latched once per frame.
module uart_tx_cfg #(
    parameter int DIV_W  = 16,
    parameter int DATA_W = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             tx_en_i,
    input  logic [DIV_W-1:0] baud_div_i,
    input  logic [1:0]       data_bits_i,
    input  logic             parity_en_i,
    input  logic             parity_odd_i,
    input  logic             stop2_i,
    input  logic             break_i,
    uart_tx_cfg_if.master    fifo_if,
    output logic             tx_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       tx_stat_o
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e            state_q;
    logic              tx_q;
    logic              fifo_rd_q;
    logic              busy_q;
    logic              done_q;
    logic [DIV_W-1:0]  cnt_q;
    logic [DIV_W-1:0]  div_q;
    logic [DATA_W-1:0] shift_q;
    logic [3:0]        nbits_q;
    logic [3:0]        bit_idx_q;
    logic              stop_idx_q;
    logic              par_en_q;
    logic              stop2_q;
    logic              par_q;

    logic [DATA_W-1:0] load_mask;
    logic              bit_end;
    logic [DIV_W-1:0]  cnt_next;
    logic              last_data;
    logic              last_stop;
    logic              div_zero;
    logic              can_start;

    assign bit_end   = (cnt_q == div_q);
    assign cnt_next  = bit_end ? '0 : cnt_q + DIV_W'(1);
    assign last_data = (bit_idx_q == nbits_q - 4'd1);
    assign last_stop = (stop_idx_q == stop2_q);
    assign div_zero  = (div_q == '0);
    assign can_start = tx_en_i && !fifo_if.fifo_empty && !break_i;

    // Mask of the data bits that belong to the frame being loaded.
    always_comb begin
        load_mask = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (i < (32'd5 + 32'(data_bits_i))) begin
                load_mask[i] = 1'b1;
            end
        end
    end

    // Frame sequencer; every output is a register updated here. done_q is
    // raised one cycle early (or on entry when a bit lasts one cycle) so the
    // pulse lands on the last cycle of the last stop bit.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            fifo_rd_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            div_q      <= '0;
            shift_q    <= '0;
            nbits_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            par_q      <= 1'b0;
        end else begin
            fifo_rd_q <= 1'b0;
            done_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    tx_q  <= ~break_i;
                    cnt_q <= '0;
                    if (can_start) begin
                        state_q   <= FETCH;
                        fifo_rd_q <= 1'b1;
                    end
                end
                FETCH: begin
                    state_q <= LOAD;
                end
                LOAD: begin
                    shift_q    <= fifo_if.fifo_data;
                    div_q      <= baud_div_i;
                    nbits_q    <= 4'd5 + {2'b00, data_bits_i};
                    par_en_q   <= parity_en_i;
                    stop2_q    <= stop2_i;
                    par_q      <= (^(fifo_if.fifo_data & load_mask)) ^ parity_odd_i;
                    busy_q     <= 1'b1;
                    cnt_q      <= '0;
                    bit_idx_q  <= '0;
                    stop_idx_q <= 1'b0;
                    tx_q       <= 1'b0;
                    state_q    <= START;
                end
                START: begin
                    cnt_q <= cnt_next;
                    if (bit_end) begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                    end
                end
                DATA: begin
                    cnt_q <= cnt_next;
                    if (bit_end) begin
                        if (last_data) begin
                            stop_idx_q <= 1'b0;
                            if (par_en_q) begin
                                state_q <= PARITY;
                                tx_q    <= par_q;
                            end else begin
                                state_q <= STOP;
                                tx_q    <= 1'b1;
                                done_q  <= !stop2_q && div_zero;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 4'd1;
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end
                end
                PARITY: begin
                    cnt_q <= cnt_next;
                    if (bit_end) begin
                        state_q    <= STOP;
                        stop_idx_q <= 1'b0;
                        tx_q       <= 1'b1;
                        done_q     <= !stop2_q && div_zero;
                    end
                end
                STOP: begin
                    cnt_q <= cnt_next;
                    if (last_stop && !div_zero && (cnt_q == div_q - DIV_W'(1))) begin
                        done_q <= 1'b1;
                    end
                    if (bit_end) begin
                        if (!last_stop) begin
                            stop_idx_q <= 1'b1;
                            done_q     <= div_zero;
                        end else if (can_start) begin
                            state_q   <= FETCH;
                            fifo_rd_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            tx_q    <= ~break_i;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_o            = tx_q;
    assign fifo_if.fifo_rd = fifo_rd_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign tx_stat_o       = {done_q, busy_q};

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: table of hand-derived frames, directed
// reset/break/enable sequences, and randomized frames against a frame model.
module tb_uart_tx_cfg;

    localparam int DIV_W  = 16;
    localparam int DATA_W = 8;

    logic             clk_i = 1'b0;
    logic             rstn_i;
    logic             tx_en_i;
    logic [DIV_W-1:0] baud_div_i;
    logic [1:0]       data_bits_i;
    logic             parity_en_i;
    logic             parity_odd_i;
    logic             stop2_i;
    logic             break_i;
    logic             tx_o;
    logic             busy_o;
    logic             done_o;
    logic [1:0]       tx_stat_o;

    uart_tx_cfg_if #(.DATA_W(DATA_W)) fifo_if ();

    uart_tx_cfg #(.DIV_W(DIV_W), .DATA_W(DATA_W)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .tx_en_i     (tx_en_i),
        .baud_div_i  (baud_div_i),
        .data_bits_i (data_bits_i),
        .parity_en_i (parity_en_i),
        .parity_odd_i(parity_odd_i),
        .stop2_i     (stop2_i),
        .break_i     (break_i),
        .fifo_if     (fifo_if),
        .tx_o        (tx_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .tx_stat_o   (tx_stat_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [7:0]  data;
        logic [1:0]  dbits;
        bit          pen;
        bit          podd;
        bit          stop2;
        int unsigned div;
        string       bits;   // expected line bits in transmission order
    } vec_t;

    int total = 0;
    int bad   = 0;
    int pops  = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] send_q[$];
    logic [5:0] exp_q[$];   // {tx, rd, busy, done, stat[1:0]} per cycle
    logic [5:0] act_q[$];
    logic [5:0] last_act;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample outputs at the falling edge and serve the FIFO model.
    task automatic cycle();
        @(negedge clk_i);
        last_act = {tx_o, fifo_if.fifo_rd, busy_o, done_o, tx_stat_o};
        if (fifo_if.fifo_rd) begin
            check("pop_nonempty", 32'(fifo_q.size() != 0), 32'd1);
            if (fifo_q.size() != 0) fifo_if.fifo_data = fifo_q.pop_front();
            pops++;
        end
        fifo_if.fifo_empty = (fifo_q.size() == 0);
    endtask

    // Line bits of one frame, straight from the framing rules.
    function automatic int frame_bits(input logic [7:0] d, input logic [1:0] db,
                                      input bit pe, input bit po, input bit s2,
                                      output bit b[16]);
        int n    = 5 + int'(db);
        int k    = 0;
        int ones = 0;
        foreach (b[i]) b[i] = 1'b0;
        b[k] = 1'b0; k++;
        for (int i = 0; i < n; i++) begin
            b[k] = d[i];
            ones += int'(d[i]);
            k++;
        end
        if (pe) begin
            b[k] = ((ones % 2) == 1) ^ po;
            k++;
        end
        b[k] = 1'b1; k++;
        if (s2) begin
            b[k] = 1'b1; k++;
        end
        return k;
    endfunction

    // Expected per-cycle trace for send_q, starting at the first pop strobe.
    task automatic build_exp(input int unsigned div, input logic [1:0] db,
                             input bit pe, input bit po, input bit s2);
        bit b[16];
        int nb;
        exp_q.delete();
        foreach (send_q[f]) begin
            logic bp;
            bp = (f != 0);
            nb = frame_bits(send_q[f], db, pe, po, s2, b);
            exp_q.push_back({1'b1, 1'b1, bp, 1'b0, 1'b0, bp});
            exp_q.push_back({1'b1, 1'b0, bp, 1'b0, 1'b0, bp});
            for (int k = 0; k < nb; k++) begin
                for (int unsigned c = 0; c <= div; c++) begin
                    logic last;
                    last = (k == nb - 1) && (c == div);
                    exp_q.push_back({b[k], 1'b0, 1'b1, last, last, 1'b1});
                end
            end
        end
        for (int s = 0; s < 4; s++) exp_q.push_back(6'b100000);
    endtask

    task automatic set_cfg(input int unsigned div, input logic [1:0] db,
                           input bit pe, input bit po, input bit s2);
        baud_div_i   = DIV_W'(div);
        data_bits_i  = db;
        parity_en_i  = pe;
        parity_odd_i = po;
        stop2_i      = s2;
    endtask

    // Queue send_q, enable, and compare the whole trace; optionally churn the
    // configuration inputs once the frame has been latched.
    task automatic run_frames(input string name, input int unsigned div, input logic [1:0] db,
                              input bit pe, input bit po, input bit s2, input bit scramble);
        int p0;
        cycle();
        set_cfg(div, db, pe, po, s2);
        foreach (send_q[i]) fifo_q.push_back(send_q[i]);
        fifo_if.fifo_empty = (fifo_q.size() == 0);
        tx_en_i = 1'b1;
        p0 = pops;
        build_exp(div, db, pe, po, s2);
        act_q.delete();
        for (int i = 0; i < exp_q.size(); i++) begin
            cycle();
            act_q.push_back(last_act);
            if (scramble && i >= 2 && i < exp_q.size() - 4) begin
                baud_div_i   = DIV_W'($urandom);
                data_bits_i  = 2'($urandom);
                parity_en_i  = 1'($urandom);
                parity_odd_i = 1'($urandom);
                stop2_i      = 1'($urandom);
                tx_en_i      = 1'($urandom);
            end
        end
        tx_en_i = 1'b0;
        set_cfg(div, db, pe, po, s2);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s trace[%0d]", name, i), 32'(act_q[i]), 32'(exp_q[i]));
        end
        check({name, " pops"}, 32'(pops - p0), 32'(send_q.size()));
    endtask

    vec_t vecs[7];

    function automatic vec_t mk(input string nm, input logic [7:0] d, input logic [1:0] db,
                                input bit pe, input bit po, input bit s2,
                                input int unsigned div, input string bits);
        vec_t v;
        v.name = nm; v.data = d; v.dbits = db; v.pen = pe; v.podd = po;
        v.stop2 = s2; v.div = div; v.bits = bits;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk("8N1_A5", 8'hA5, 2'd3, 0, 0, 0, 3, "0101001011");
        vecs[1] = mk("7E1_B5", 8'hB5, 2'd2, 1, 0, 0, 1, "0101011001");
        vecs[2] = mk("5O2_FF", 8'hFF, 2'd0, 1, 1, 1, 0, "011111011");
        vecs[3] = mk("5E2_FF", 8'hFF, 2'd0, 1, 0, 1, 0, "011111111");
        vecs[4] = mk("6N2_2A", 8'h2A, 2'd1, 0, 0, 1, 2, "001010111");
        vecs[5] = mk("8O1_00", 8'h00, 2'd3, 1, 1, 0, 0, "00000000011");
        vecs[6] = mk("8E2_81", 8'h81, 2'd3, 1, 0, 1, 4, "010000001011");

        rstn_i = 1'b0;
        tx_en_i = 1'b0;
        break_i = 1'b0;
        set_cfg(0, 2'd3, 0, 0, 0);
        fifo_if.fifo_data  = '0;
        fifo_if.fifo_empty = 1'b1;
        repeat (3) @(negedge clk_i);
        check("in_reset", 32'({tx_o, fifo_if.fifo_rd, busy_o, done_o, tx_stat_o}), 32'h20);
        rstn_i = 1'b1;
        cycle();
        check("reset_state", 32'(last_act), 32'h20);

        // Table: hand-derived line bits sampled mid-bit, plus done position.
        foreach (vecs[v]) begin
            int di;
            send_q.delete();
            send_q.push_back(vecs[v].data);
            run_frames(vecs[v].name, vecs[v].div, vecs[v].dbits, vecs[v].pen,
                       vecs[v].podd, vecs[v].stop2, 1'b0);
            for (int k = 0; k < vecs[v].bits.len(); k++) begin
                int idx;
                idx = 2 + k * int'(vecs[v].div + 1) + int'(vecs[v].div / 2);
                check($sformatf("%s bit%0d", vecs[v].name, k), 32'(act_q[idx][5]),
                      32'(vecs[v].bits.getc(k) == "1"));
            end
            di = -1;
            for (int i = 0; i < act_q.size(); i++) begin
                if (act_q[i][2] && di < 0) di = i;
            end
            check({vecs[v].name, " done_at"}, 32'(di),
                  32'(2 + vecs[v].bits.len() * int'(vecs[v].div + 1) - 1));
        end

        // Three queued bytes back to back.
        send_q.delete();
        send_q.push_back(8'h11); send_q.push_back(8'hE7); send_q.push_back(8'h5C);
        run_frames("b2b_8N1_d2", 2, 2'd3, 0, 0, 0, 1'b0);

        // Enable dropped mid-frame: frame completes, second byte stays queued.
        cycle();
        set_cfg(1, 2'd3, 0, 0, 0);
        fifo_q.push_back(8'h6B); fifo_q.push_back(8'h94);
        fifo_if.fifo_empty = 1'b0;
        tx_en_i = 1'b1;
        send_q.delete(); send_q.push_back(8'h6B);
        build_exp(1, 2'd3, 0, 0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            cycle();
            check($sformatf("en_off trace[%0d]", i), 32'(last_act), 32'(exp_q[i]));
            if (i == 2) tx_en_i = 1'b0;
        end
        check("en_off_no_pop", 32'(fifo_q.size()), 32'd1);
        fifo_q.delete();
        fifo_if.fifo_empty = 1'b1;

        // Asynchronous reset during data bit 3, then a clean frame.
        cycle();
        set_cfg(3, 2'd3, 0, 0, 0);
        fifo_q.push_back(8'h37);
        fifo_if.fifo_empty = 1'b0;
        tx_en_i = 1'b1;
        for (int i = 0; i <= 18; i++) cycle();
        check("pre_reset_bit3", 32'(last_act[5:3]), 32'b001);
        rstn_i = 1'b0;
        #1;
        check("async_reset", 32'({tx_o, fifo_if.fifo_rd, busy_o, done_o}), 32'b1000);
        @(negedge clk_i);
        rstn_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("post_reset_idle", 32'(last_act), 32'h20);
        end
        send_q.delete(); send_q.push_back(8'hC9);
        run_frames("after_reset", 3, 2'd3, 0, 0, 0, 1'b0);

        // Break raised mid-frame with more data queued.
        begin
            int found;
            int rdc;
            cycle();
            set_cfg(1, 2'd3, 0, 0, 0);
            fifo_q.push_back(8'h5A); fifo_q.push_back(8'hC3);
            fifo_if.fifo_empty = 1'b0;
            tx_en_i = 1'b1;
            send_q.delete(); send_q.push_back(8'h5A);
            build_exp(1, 2'd3, 0, 0, 0);
            for (int i = 0; i < 22; i++) begin
                cycle();
                check($sformatf("brk_frame[%0d]", i), 32'(last_act), 32'(exp_q[i]));
                if (i == 10) break_i = 1'b1;
            end
            for (int i = 0; i < 8; i++) begin
                cycle();
                check("brk_hold", 32'(last_act[5:3]), 32'b000);
            end
            break_i = 1'b0;
            cycle();
            check("brk_release_high", 32'(last_act[5]), 32'd1);
            rdc = int'(last_act[4]);
            found = 0;
            for (int j = 0; j < 4 && found == 0; j++) begin
                cycle();
                rdc += int'(last_act[4]);
                if (last_act[5] == 1'b0) found = 1;
            end
            check("brk_restart_found", 32'(found), 32'd1);
            check("brk_restart_pops", 32'(rdc), 32'd1);
            send_q.delete(); send_q.push_back(8'hC3);
            build_exp(1, 2'd3, 0, 0, 0);
            if (found == 1) begin
                check("brk_f2[2]", 32'(last_act), 32'(exp_q[2]));
                for (int i = 3; i < exp_q.size(); i++) begin
                    cycle();
                    check($sformatf("brk_f2[%0d]", i), 32'(last_act), 32'(exp_q[i]));
                end
            end
            tx_en_i = 1'b0;
        end

        // Randomized frames against the model.
        for (int it = 0; it < 25; it++) begin
            int n;
            int unsigned dv;
            logic [1:0] db;
            bit pe, po, s2;
            n  = int'($urandom_range(1, 3));
            dv = $urandom_range(0, 4);
            db = 2'($urandom);
            pe = 1'($urandom);
            po = 1'($urandom);
            s2 = 1'($urandom);
            send_q.delete();
            for (int k = 0; k < n; k++) send_q.push_back(8'($urandom));
            run_frames($sformatf("rand%0d", it), dv, db, pe, po, s2, n == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
